// File: rtl/booth_mul_pkg.sv
// ---------------------------------------------------------------------------
// booth_mul_pkg
// Shared types and constants for the Booth multiplier sequencer slice.
//   state_t      sequencer FSM encoding
//   W_DEFAULT    default operand width
//   PW_DEFAULT   default product width (2*W)
// ---------------------------------------------------------------------------
package booth_mul_pkg;

    localparam int W_DEFAULT  = 16;
    localparam int PW_DEFAULT = 2 * W_DEFAULT;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_LOAD_M = 3'd2,
        ST_LOAD_Q = 3'd3,
        ST_WAIT   = 3'd4
    } state_t;

endpackage

// File: rtl/booth_mul_sequencer_if.sv
// ---------------------------------------------------------------------------
// booth_mul_sequencer_if
// Bundles the upstream operand handshake, the downstream product handshake
// and the multiplier-facing start/operand/done bus.
//   slave  : the sequencer side
//   master : the environment side (operand source, product sink, multiplier)
// ---------------------------------------------------------------------------
interface booth_mul_sequencer_if
    import booth_mul_pkg::*;
#(
    parameter int W = W_DEFAULT
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_mcand;
    logic [W-1:0]     in_mplier;

    logic             mul_start;
    logic [W-1:0]     mul_data_in;
    logic             mul_done;
    logic [2*W-1:0]   mul_product;

    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   out_product;
    logic             out_timeout;

    modport slave (
        input  in_valid, in_mcand, in_mplier, mul_done, mul_product, out_ready,
        output in_ready, mul_start, mul_data_in, out_valid, out_product, out_timeout
    );

    modport master (
        output in_valid, in_mcand, in_mplier, mul_done, mul_product, out_ready,
        input  in_ready, mul_start, mul_data_in, out_valid, out_product, out_timeout
    );

endinterface

// File: rtl/booth_mul_watchdog.sv
// ---------------------------------------------------------------------------
// booth_mul_watchdog
// Clearable up-counter with a terminal-count flag, for bounding the wait on
// any multicycle unit.
//   clock, reset_n : clock, async active-low reset
//   clr            : synchronous clear to zero (wins over inc)
//   inc            : count up by one
//   tc             : count has reached LIMIT
// The counter parks at LIMIT instead of wrapping; LIMIT must fit in CW bits.
// ---------------------------------------------------------------------------
module booth_mul_watchdog #(
    parameter int CW    = 7,
    parameter int LIMIT = 63
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == LIM);

endmodule

// File: rtl/booth_mul_sequencer.sv
// ---------------------------------------------------------------------------
// booth_mul_sequencer
// Front end for the Booth multiplier: accepts a signed operand pair, issues
// the start pulse and the time-multiplexed operand bus (multiplicand, then
// multiplier), waits for done under a watchdog and holds the 2W-bit product
// in a one-entry buffer until the consumer takes it.
//   clock, reset_n : clock, async active-low reset
//   bus (slave)    : operand in, multiplier bus, product out
//   busy           : FSM is not idle
// TIMEOUT must be at least W+8 and below 2**CW.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for an operand pair (and for the buffer to drain)
//   ISSUE   | start pulse high, multiplicand on the operand bus
//   LOAD_M  | multiplicand held while the multiplier loads M
//   LOAD_Q  | multiplier operand on the bus while it loads Q; watchdog clear
//   WAIT    | waiting for done; watchdog running
// ---------------------------------------------------------------------------
module booth_mul_sequencer
    import booth_mul_pkg::*;
#(
    parameter int W       = W_DEFAULT,
    parameter int TIMEOUT = 64,
    parameter int CW      = 7
) (
    input  logic                  clock,
    input  logic                  reset_n,
    booth_mul_sequencer_if.slave  bus,
    output logic                  busy
);

    localparam int PW = 2 * W;

    state_t          state;
    logic [W-1:0]    mcand_q;
    logic [W-1:0]    mplier_q;
    logic            mul_start_q;
    logic            out_valid_q;
    logic [PW-1:0]   out_product_q;
    logic            out_timeout_q;

    logic            in_ready_c;
    logic            in_xfer;
    logic            out_xfer;
    logic            wd_tc;

    // The buffer may drain in the same cycle a new pair is accepted.
    assign in_ready_c = (state == ST_IDLE) && (!out_valid_q || bus.out_ready);
    assign in_xfer    = bus.in_valid && in_ready_c;
    assign out_xfer   = out_valid_q && bus.out_ready;

    booth_mul_watchdog #(
        .CW    (CW),
        .LIMIT (TIMEOUT - 1)
    ) u_watchdog (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (state == ST_LOAD_Q),
        .inc     (state == ST_WAIT),
        .tc      (wd_tc)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            mcand_q       <= '0;
            mplier_q      <= '0;
            mul_start_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
            out_timeout_q <= 1'b0;
        end else begin
            mul_start_q <= 1'b0;
            if (out_xfer) begin
                out_valid_q <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (in_xfer) begin
                        mcand_q     <= bus.in_mcand;
                        mplier_q    <= bus.in_mplier;
                        mul_start_q <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_LOAD_M;
                end
                ST_LOAD_M: begin
                    state <= ST_LOAD_Q;
                end
                ST_LOAD_Q: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done seen on the final watchdog cycle still counts.
                    if (bus.mul_done) begin
                        out_product_q <= bus.mul_product;
                        out_timeout_q <= 1'b0;
                        out_valid_q   <= 1'b1;
                        state         <= ST_IDLE;
                    end else if (wd_tc) begin
                        out_product_q <= '0;
                        out_timeout_q <= 1'b1;
                        out_valid_q   <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Operand bus is a pure mux of flops: multiplicand for the start and M
    // load cycles, multiplier operand from the Q load onward.
    assign bus.mul_data_in = ((state == ST_ISSUE) || (state == ST_LOAD_M)) ? mcand_q : mplier_q;

    assign bus.in_ready    = in_ready_c;
    assign bus.mul_start   = mul_start_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_product = out_product_q;
    assign bus.out_timeout = out_timeout_q;
    assign busy            = (state != ST_IDLE);

endmodule

// File: tb/tb_booth_mul_sequencer.sv
// ---------------------------------------------------------------------------
// tb_booth_mul_sequencer
// Directed bench for booth_mul_sequencer with a behavioural multiplier that
// captures M/Q from the operand bus and raises done a set number of cycles
// after the start pulse (mdl_delay < 0: never).
// ---------------------------------------------------------------------------
module tb_booth_mul_sequencer;

    localparam int W  = 16;
    localparam int PW = 2 * W;

    logic clock;
    logic reset_n;
    logic busy;

    booth_mul_sequencer_if #(.W(W)) bus ();

    booth_mul_sequencer #(
        .W       (W),
        .TIMEOUT (64),
        .CW      (7)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus),
        .busy    (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural multiplier
    int            mdl_delay;
    int            mdl_cnt;
    int            mdl_ph;
    int            starts;
    logic [W-1:0]  m_cap;
    logic [W-1:0]  q_cap;
    logic          mdl_done;
    logic [PW-1:0] mdl_prod;

    assign bus.mul_done    = mdl_done;
    assign bus.mul_product = mdl_prod;

    initial starts = 0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mdl_done <= 1'b0;
            mdl_cnt  <= 0;
            mdl_ph   <= 0;
            mdl_prod <= '0;
            m_cap    <= '0;
            q_cap    <= '0;
        end else if (bus.mul_start) begin
            starts   <= starts + 1;
            mdl_done <= 1'b0;
            mdl_ph   <= 1;
            mdl_cnt  <= mdl_delay;
        end else begin
            if (mdl_ph == 1) begin
                m_cap  <= bus.mul_data_in;
                mdl_ph <= 2;
            end else if (mdl_ph == 2) begin
                q_cap  <= bus.mul_data_in;
                mdl_ph <= 0;
            end
            if (mdl_cnt > 0) begin
                mdl_cnt <= mdl_cnt - 1;
                if (mdl_cnt == 1) begin
                    mdl_done <= 1'b1;
                    mdl_prod <= $signed(m_cap) * $signed(q_cap);
                end
            end
        end
    end

    // Called at a negedge; returns just after the transfer edge.
    task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        bus.in_valid  = 1'b1;
        bus.in_mcand  = a;
        bus.in_mplier = b;
        #1;
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Counts edges from the presentation cycle to the first cycle with
    // out_valid high; returns at a negedge.
    task automatic wait_out(output int lat, input string tag);
        lat = 1;
        forever begin
            @(negedge clock);
            if (lat == 1) begin
                chk({tag, "_busy"}, 64'(busy), 64'd1);
                chk({tag, "_in_ready_busy"}, 64'(bus.in_ready), 64'd0);
            end
            if (bus.out_valid) break;
            if (lat > 200) begin
                chk({tag, "_out_valid_timeout"}, 64'(bus.out_valid), 64'd1);
                break;
            end
            @(posedge clock);
            lat++;
        end
    endtask

    // Called at a negedge with out_valid high.
    task automatic drain(input int hold, input logic [PW-1:0] exp_prod, input string tag);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            @(negedge clock);
            chk({tag, "_hold_valid"}, 64'(bus.out_valid), 64'd1);
            chk({tag, "_hold_prod"}, 64'(bus.out_product), 64'(exp_prod));
        end
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clock);
        chk({tag, "_drained"}, 64'(bus.out_valid), 64'd0);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int delay,
                          input logic [PW-1:0] exp_prod, input logic exp_to,
                          input int exp_lat, input int hold, input string tag);
        int lat;
        int s0;
        mdl_delay = delay;
        s0 = starts;
        send_pair(a, b, tag);
        wait_out(lat, tag);
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_product"}, 64'(bus.out_product), 64'(exp_prod));
        chk({tag, "_timeout"}, 64'(bus.out_timeout), 64'(exp_to));
        chk({tag, "_idle"}, 64'(busy), 64'd0);
        chk({tag, "_starts"}, 64'(starts - s0), 64'd1);
        drain(hold, exp_prod, tag);
    endtask

    initial begin
        int lat;
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_mcand  = '0;
        bus.in_mplier = '0;
        bus.out_ready = 1'b0;
        mdl_delay     = -1;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_in_ready",  64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy",      64'(busy), 64'd0);
        chk("rst_start",     64'(bus.mul_start), 64'd0);
        chk("rst_data_in",   64'(bus.mul_data_in), 64'd0);
        chk("rst_product",   64'(bus.out_product), 64'd0);
        chk("rst_timeout",   64'(bus.out_timeout), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Basic 3 x 5: done 18 cycles after start -> 17 WAIT cycles
        run_op(16'd3, 16'd5, 18, 32'h0000_000F, 1'b0, 21, 3, "basic");
        chk("basic_m_load", 64'(m_cap), 64'd3);
        chk("basic_q_load", 64'(q_cap), 64'd5);

        // Signed -7 x 6, product held for a few cycles before drain
        run_op(16'hFFF9, 16'd6, 5, 32'hFFFF_FFD6, 1'b0, 8, 4, "signed");
        chk("signed_m_load", 64'(m_cap), 64'hFFF9);

        // Backpressure and back-to-back: 2 x 2 then 4 x 4
        mdl_delay = 3;
        send_pair(16'd2, 16'd2, "bp1");
        wait_out(lat, "bp1");
        chk("bp1_latency", 64'(lat), 64'd6);
        chk("bp1_product", 64'(bus.out_product), 64'd4);
        bus.in_valid  = 1'b1;
        bus.in_mcand  = 16'd4;
        bus.in_mplier = 16'd4;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_stall_in_ready", 64'(bus.in_ready), 64'd0);
            chk("bp_stall_valid", 64'(bus.out_valid), 64'd1);
            @(posedge clock);
            @(negedge clock);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_drain_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clock);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        wait_out(lat, "bp2");
        chk("bp2_latency", 64'(lat), 64'd6);
        chk("bp2_product", 64'(bus.out_product), 64'd16);
        drain(0, 32'd16, "bp2");

        // Watchdog abort: done never comes
        run_op(16'd7, 16'd7, -1, 32'h0, 1'b1, 68, 1, "timeout");

        // Done on the last watchdog cycle wins
        run_op(16'd100, 16'hFFFD, 65, 32'hFFFF_FED4, 1'b0, 68, 0, "terminal");

        // Done one cycle too late: aborted
        run_op(16'd9, 16'd9, 66, 32'h0, 1'b1, 68, 0, "late");

        // Reset in the middle of WAIT
        mdl_delay = 30;
        send_pair(16'd5, 16'd5, "rstmid");
        repeat (10) @(posedge clock);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rstmid_busy",      64'(busy), 64'd0);
        chk("rstmid_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rstmid_start",     64'(bus.mul_start), 64'd0);
        chk("rstmid_in_ready",  64'(bus.in_ready), 64'd1);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rstmid_no_output", 64'(bus.out_valid), 64'd0);
        run_op(16'd1, 16'd1, 4, 32'd1, 1'b0, 7, 0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
